// File: rtl/hash_pad_stream.sv
// hash_pad_stream: turns a word stream carrying one message into padded
// 16-word hash blocks. It appends the 0x80 marker, zero fill and the bit-length
// field, and adds an extra length-only block when the length does not fit.
module hash_pad_stream #(
  parameter int W     = 32,
  parameter int LEN_W = 2*W
) (
  input  logic                    sys_clk,
  input  logic                    sys_reset,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [W-1:0]            in_data,
  input  logic                    in_sop,
  input  logic                    in_eop,
  input  logic [$clog2(W/8):0]    in_bytes,
  input  logic                    le_mode,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [16*W-1:0]         out_block,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    err
);

  localparam int BPW = W/8;
  localparam int BW  = $clog2(W/8) + 1;
  localparam int LW2 = 2*W;

  typedef enum logic [1:0] {IDLE, FILL, EMIT, LENBLK} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     blk [16];
  logic [W-1:0]     blk_nxt [16];
  logic [3:0]       wcnt, wcnt_nxt;
  logic [LEN_W-1:0] len_cnt, len_nxt;
  logic             le_reg, le_nxt;
  logic             first_pend, first_pend_nxt;
  logic             len_pend, len_pend_nxt;
  logic             spill, spill_nxt;
  logic             first_q, first_nxt;
  logic             last_q, last_nxt;
  logic             err_q, err_nxt;

  logic             le_in, le_len, full_word, fits;
  logic [3:0]       slot;
  logic [LEN_W-1:0] len_acc;
  logic [LW2-1:0]   len_ext;
  logic [W-1:0]     len_w14, len_w15, marker_word;

  // Keeps the valid leading bytes of a word, optionally places the 0x80 marker
  // right after them, and byte-reverses the result for little-endian cores.
  function automatic logic [W-1:0] pack_word(input logic [W-1:0] d,
                                             input logic [BW-1:0] nb,
                                             input logic mark,
                                             input logic le);
    logic [W-1:0] r;
    logic [W-1:0] s;
    r = '0;
    for (int j = 0; j < BPW; j++) begin
      if (j < int'(nb)) r[W-1-8*j -: 8] = d[W-1-8*j -: 8];
      else if (mark && (j == int'(nb))) r[W-1-8*j -: 8] = 8'h80;
    end
    s = r;
    if (le) begin
      for (int j = 0; j < BPW; j++) s[8*j +: 8] = r[W-1-8*j -: 8];
    end
    return s;
  endfunction

  assign in_rdy    = (state == IDLE) || (state == FILL);
  assign out_val   = (state == EMIT);
  assign out_first = first_q;
  assign out_last  = last_q;
  assign err       = err_q;

  // Flatten the block registers so word 0 sits in the most significant slice.
  always_comb begin
    out_block = '0;
    for (int i = 0; i < 16; i++) out_block[(16-i)*W-1 -: W] = blk[i];
  end

  // Next-state and datapath decisions for collection, emission and length block.
  always_comb begin
    state_nxt      = state;
    blk_nxt        = blk;
    wcnt_nxt       = wcnt;
    len_nxt        = len_cnt;
    le_nxt         = le_reg;
    first_pend_nxt = first_pend;
    len_pend_nxt   = len_pend;
    spill_nxt      = spill;
    first_nxt      = first_q;
    last_nxt       = last_q;
    err_nxt        = 1'b0;
    fits           = 1'b0;

    le_in     = (W == 32) ? (in_sop ? le_mode : le_reg) : 1'b0;
    slot      = in_sop ? 4'd0 : wcnt;
    full_word = (int'(in_bytes) >= BPW);
    len_acc   = (in_sop ? {LEN_W{1'b0}} : len_cnt) + LEN_W'({in_bytes, 3'b000});

    le_len      = (state == LENBLK) ? le_reg : le_in;
    len_ext     = LW2'((state == LENBLK) ? len_cnt : len_acc);
    len_w14     = le_len ? len_ext[W-1:0] : len_ext[LW2-1:W];
    len_w15     = le_len ? len_ext[LW2-1:W] : len_ext[W-1:0];
    marker_word = pack_word('0, '0, 1'b1, le_len);

    case (state)
      IDLE, FILL: begin
        if (in_val) begin
          if ((state == IDLE) && !in_sop) begin
            err_nxt = 1'b1;
          end else begin
            if ((state == FILL) && in_sop) err_nxt = 1'b1;
            if (in_sop) begin
              le_nxt         = le_in;
              first_pend_nxt = 1'b1;
            end
            len_nxt = len_acc;
            if (slot == 4'd0) begin
              for (int i = 0; i < 16; i++) blk_nxt[i] = '0;
            end
            blk_nxt[slot] = pack_word(in_data, in_bytes, in_eop && !full_word, le_in);
            if (!in_eop) begin
              if (slot == 4'd15) begin
                state_nxt      = EMIT;
                wcnt_nxt       = 4'd0;
                first_nxt      = in_sop || first_pend;
                first_pend_nxt = 1'b0;
                last_nxt       = 1'b0;
              end else begin
                state_nxt = FILL;
                wcnt_nxt  = slot + 4'd1;
              end
            end else begin
              state_nxt      = EMIT;
              wcnt_nxt       = 4'd0;
              first_nxt      = in_sop || first_pend;
              first_pend_nxt = 1'b0;
              if (!full_word) begin
                fits = (slot <= 4'd13);
              end else begin
                fits = (slot <= 4'd12);
                if (slot != 4'd15) blk_nxt[slot + 4'd1] = marker_word;
                else spill_nxt = 1'b1;
              end
              if (fits) begin
                blk_nxt[14]  = len_w14;
                blk_nxt[15]  = len_w15;
                last_nxt     = 1'b1;
                len_pend_nxt = 1'b0;
              end else begin
                last_nxt     = 1'b0;
                len_pend_nxt = 1'b1;
              end
            end
          end
        end
      end
      EMIT: begin
        if (out_rdy) begin
          if (len_pend) begin
            state_nxt    = LENBLK;
            len_pend_nxt = 1'b0;
          end else if (last_q) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      LENBLK: begin
        for (int i = 0; i < 16; i++) blk_nxt[i] = '0;
        if (spill) blk_nxt[0] = marker_word;
        blk_nxt[14] = len_w14;
        blk_nxt[15] = len_w15;
        spill_nxt   = 1'b0;
        first_nxt   = 1'b0;
        last_nxt    = 1'b1;
        state_nxt   = EMIT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any partially built block.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state      <= IDLE;
      for (int i = 0; i < 16; i++) blk[i] <= '0;
      wcnt       <= 4'd0;
      len_cnt    <= '0;
      le_reg     <= 1'b0;
      first_pend <= 1'b0;
      len_pend   <= 1'b0;
      spill      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      blk        <= blk_nxt;
      wcnt       <= wcnt_nxt;
      len_cnt    <= len_nxt;
      le_reg     <= le_nxt;
      first_pend <= first_pend_nxt;
      len_pend   <= len_pend_nxt;
      spill      <= spill_nxt;
      first_q    <= first_nxt;
      last_q     <= last_nxt;
      err_q      <= err_nxt;
    end
  end

endmodule
